// File: rtl/adder_sum_decoder.sv
// Bit-serial operand recovery: given z = a + b, computes b = z - a one bit per
// clock (LSB first) behind valid/ready handshakes, flagging out-of-range results.
module adder_sum_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   z_in,
  input  logic [WIDTH-1:0] a_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b_out,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH:0]   z_q;
  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   diff_q;
  logic [WIDTH:0]   diff_d;
  logic             borrow_q;
  logic             borrow_d;
  logic             d_bit;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] b_q;
  logic             err_q;

  // One full-subtractor slice; the difference bit enters at the top so the
  // first (LSB) bit ends at bit 0 after WIDTH+1 shifts.
  always_comb begin
    d_bit    = z_q[0] ^ a_q[0] ^ borrow_q;
    borrow_d = (~z_q[0] & a_q[0]) | (~(z_q[0] ^ a_q[0]) & borrow_q);
    diff_d   = {d_bit, diff_q[WIDTH:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      z_q         <= '0;
      a_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      b_q         <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            z_q      <= z_in;
            a_q      <= {1'b0, a_in};
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          diff_q   <= diff_d;
          borrow_q <= borrow_d;
          z_q      <= {1'b0, z_q[WIDTH:1]};
          a_q      <= {1'b0, a_q[WIDTH:1]};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH)) begin
            // A leftover borrow means z < a; a set top bit means z - a >= 2^WIDTH.
            b_q         <= diff_d[WIDTH-1:0];
            err_q       <= diff_d[WIDTH] | borrow_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign b_out     = b_q;
  assign err       = err_q;

endmodule

// File: tb/tb_adder_sum_decoder.sv
// Scoreboard bench for adder_sum_decoder: stimulus pushes expected {err,b} at
// each accepted input; a monitor pops and compares at every output handshake.
module tb_adder_sum_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] z_in;
  logic [3:0] a_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] b_out;
  logic       err;

  int n_vec  = 0;
  int n_miss = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  adder_sum_decoder #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .z_in(z_in), .a_in(a_in), .out_valid(out_valid), .out_ready(out_ready),
    .b_out(b_out), .err(err)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: plain integer subtraction plus range check.
  function automatic logic [4:0] model(input int z, input int a);
    int d;
    logic e;
    d = z - a;
    e = (d < 0) || (d > 15);
    return {e, 4'(d & 15)};
  endfunction

  // Present z/a until accepted; optionally keep in_valid high afterwards.
  task automatic send(input int z, input int a, input bit hold);
    bit ok;
    ok = 1'b0;
    z_in = 5'(z);
    a_in = 4'(a);
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (ok) begin
      exp_q.push_back(model(z, a));
      $display("op z=%0d a=%0d accepted, expect b=%0d err=%0d",
               z, a, model(z, a) & 15, model(z, a) >> 4);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = k;
    end
  endtask

  // Monitor: handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        $display("result b=%0d err=%0d (expect b=%0d err=%0d)", b_out, err, e[3:0], e[4]);
        chk("b_out", int'(b_out), int'(e[3:0]));
        chk("err", int'(err), int'(e[4]));
      end
    end
  end

  initial begin
    int lat;
    logic [3:0] hb;
    logic he;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; z_in = '0; a_in = '0;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_b", int'(b_out), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: latency
    send(18, 15, 1'b0);
    wait_valid(lat);
    chk("latency", lat, 5);
    repeat (3) @(posedge clk);
    #1;

    // 2/3: directed values incl. wrap and overflow
    send(30, 15, 1'b0); repeat (8) @(posedge clk); #1;
    send(0, 0, 1'b0);   repeat (8) @(posedge clk); #1;
    send(16, 0, 1'b0);  repeat (8) @(posedge clk); #1;

    // 4: hold in DONE with out_ready low while a new request waits
    out_ready = 1'b0;
    send(0, 1, 1'b0);
    wait_valid(lat);
    chk("hold_valid_seen", int'(lat > 0), 1);
    hb = b_out; he = err;
    chk("hold_b_first", int'(hb), 15);
    chk("hold_err_first", int'(he), 1);
    z_in = 5'd7; a_in = 4'd2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_b", int'(b_out), int'(hb));
      chk("hold_err", int'(err), int'(he));
      chk("hold_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // 5: asynchronous abort during the third SHIFT cycle
    send(27, 3, 1'b0);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_b", int'(b_out), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(9, 4, 1'b0);
    repeat (8) @(posedge clk); #1;

    // 6: back-to-back with in_valid held, then random sweep
    send(31, 15, 1'b1);
    send(20, 5, 1'b1);
    send(3, 9, 1'b1);
    send(17, 1, 1'b0);
    repeat (8) @(posedge clk); #1;
    for (int i = 0; i < 256; i++) send(int'($urandom_range(31, 0)), int'($urandom_range(15, 0)), i != 255);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
